disp_countdown_ctrl: RTL

DISP_COUNTDOWN_CTRL -- requirements
Module: disp_countdown_ctrl

---
 rtl/disp_pkg.sv | 23 ++
 rtl/disp_countdown_ctrl_tick_gen.sv | 36 +++
 rtl/disp_countdown_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the countdown display controller.
// The blink feature is selected with DISP_COUNTDOWN_BLINK_EN.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHOW_OP = 2'd1,
    COUNT   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [2:0] OP_T = 3'd0;
  localparam logic [2:0] OP_A = 3'd1;
  localparam logic [2:0] OP_B = 3'd2;
  localparam logic [2:0] OP_C = 3'd3;

  localparam logic MODE_SYM = 1'b0;
  localparam logic MODE_DIG = 1'b1;

  // Digits at or below this value blink when the blink feature is built in.
  localparam logic [3:0] BLINK_MAX_DIGIT = 4'd3;

endpackage

// File: rtl/disp_countdown_ctrl_tick_gen.sv
// Free-running tick generator: one-cycle pulse every TICK_CYCLES cycles, restartable via clr.
// With DISP_COUNTDOWN_BLINK_EN the phase counter is exported for blink timing.
module tick_gen #(
  parameter int TICK_CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
`ifdef DISP_COUNTDOWN_BLINK_EN
  output logic [$clog2(TICK_CYCLES)-1:0] count,
`endif
  output logic tick
);

  localparam int CW = $clog2(TICK_CYCLES);

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CW'(TICK_CYCLES - 1));

  // clr restarts the phase so the first tick lands TICK_CYCLES-1 cycles after a state entry.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

`ifdef DISP_COUNTDOWN_BLINK_EN
  assign count = cnt_q;
`endif

endmodule

// File: rtl/disp_countdown_ctrl.sv
// Countdown display controller: shows an operation symbol, then counts a digit down to zero.
// Optional blinking of the last digits is built in with DISP_COUNTDOWN_BLINK_EN.
module disp_countdown_ctrl
  import disp_pkg::*;
#(
  parameter int TICK_CYCLES   = 100_000_000,
  parameter int OP_HOLD_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic [2:0] i_req_op,
  input  logic [3:0] i_req_secs,
  input  logic       i_abort,
  output logic       o_en,
  output logic       o_disp_mode,
  output logic [2:0] o_op_code,
  output logic [3:0] o_digit_val,
  output logic       o_busy,
  output logic       o_done
);

  localparam int HW = $clog2(OP_HOLD_TICKS + 1);

  state_t        state_q;
  state_t        state_d;
  logic [2:0]    op_q;
  logic [3:0]    val_q;
  logic [HW-1:0] hold_q;
  logic          tick;
  logic          clr;
  logic          last_hold;
  logic          count_en;

  assign last_hold = (hold_q == HW'(OP_HOLD_TICKS - 1));
  assign clr       = (state_d != state_q);

`ifdef DISP_COUNTDOWN_BLINK_EN
  localparam int CW = $clog2(TICK_CYCLES);
  logic [CW-1:0] tick_count;

  tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .count (tick_count),
    .tick  (tick)
  );

  // Low digits go dark for the second half of each tick period.
  assign count_en = !((val_q <= BLINK_MAX_DIGIT) && (tick_count >= CW'(TICK_CYCLES / 2)));
`else
  tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  assign count_en = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs decode state and registered data only; inputs steer next state alone.
  always_comb begin
    state_d     = state_q;
    o_req_ready = 1'b0;
    o_en        = 1'b0;
    o_disp_mode = MODE_SYM;
    o_op_code   = 3'd0;
    o_digit_val = 4'd0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (state_q)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          state_d = SHOW_OP;
        end
      end
      SHOW_OP: begin
        o_en        = 1'b1;
        o_busy      = 1'b1;
        o_disp_mode = MODE_SYM;
        o_op_code   = op_q;
        if (i_abort) begin
          state_d = IDLE;
        end else if (tick && last_hold) begin
          state_d = COUNT;
        end
      end
      COUNT: begin
        o_en        = count_en;
        o_busy      = 1'b1;
        o_disp_mode = MODE_DIG;
        o_digit_val = val_q;
        if (i_abort) begin
          state_d = IDLE;
        end else if (tick && (val_q == 4'd0)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        o_busy  = 1'b1;
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request data, hold-tick count and countdown value.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= OP_T;
      val_q  <= 4'd0;
      hold_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_req_valid) begin
            op_q   <= i_req_op;
            val_q  <= i_req_secs;
            hold_q <= '0;
          end
        end
        SHOW_OP: begin
          if (!i_abort && tick && !last_hold) begin
            hold_q <= hold_q + HW'(1);
          end
        end
        COUNT: begin
          if (!i_abort && tick && (val_q != 4'd0)) begin
            val_q <= val_q - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
